channel_cfg_scheduler: RTL and testbench

Configuration controller for the bank of output channel multiplexers. It collects per-channel enable/source-select writes into shadow registers and applies them to all channels atomically on the next rising PPS edge after a commit request. Each channel therefore switches between the divided PPS and the generated pulse on a second boundary, never mid-period. Its outputs drive the enable and selector inputs of every channel multiplexer.

---
 rtl/channel_cfg_pkg.sv | 15 +
 rtl/pps_edge_detect.sv | 19 +
 rtl/channel_cfg_scheduler.sv | 130 +++++++++++++
 tb/tb_channel_cfg_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/channel_cfg_pkg.sv
// Shared types and defaults for the channel configuration scheduler.
package channel_cfg_pkg;

  // Commit sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DEF_N_CHANNELS     = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 200_000_000;
  localparam int unsigned DEF_CH_IDX_W       = $clog2(DEF_N_CHANNELS);

endpackage

// File: rtl/pps_edge_detect.sv
// Rising-edge detector for a PPS level already synchronous to i_clk.
module pps_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pps,
  output logic o_rise
);

  logic r_pps_q;

  // Previous PPS sample; cleared so a high level right after reset reads as an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_pps_q <= 1'b0;
    else       r_pps_q <= i_pps;
  end

  assign o_rise = i_pps & ~r_pps_q;

endmodule

// File: rtl/channel_cfg_scheduler.sv
// Shadow/active channel configuration with atomic apply on a PPS rising edge.
// Optional ARMED watchdog enabled by defining CHANNEL_CFG_TIMEOUT_EN.
module channel_cfg_scheduler
  import channel_cfg_pkg::*;
#(
  parameter int unsigned N_CHANNELS     = DEF_N_CHANNELS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_pps,
  input  logic                          i_cfg_valid,
  output logic                          o_cfg_ready,
  input  logic [$clog2(N_CHANNELS)-1:0] i_cfg_channel,
  input  logic                          i_cfg_enable,
  input  logic                          i_cfg_selector,
  input  logic                          i_commit,
  input  logic                          i_abort,
  output logic [N_CHANNELS-1:0]         o_enable,
  output logic [N_CHANNELS-1:0]         o_selector,
  output logic                          o_armed,
  output logic                          o_commit_done,
  output logic                          o_timeout
);

  state_e                r_state;
  state_e                w_next;
  logic                  w_rise;
  logic                  w_wr;
  logic                  w_apply;
  logic                  w_timeout;
  logic                  w_expire;
  logic [N_CHANNELS-1:0] r_shadow_en;
  logic [N_CHANNELS-1:0] r_shadow_sel;
  logic [N_CHANNELS-1:0] r_active_en;
  logic [N_CHANNELS-1:0] r_active_sel;
  logic                  r_cfg_ready;
  logic                  r_armed;
  logic                  r_commit_done;
  logic                  r_timeout;

  pps_edge_detect u_pps_edge (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_pps (i_pps),
    .o_rise(w_rise)
  );

  assign w_wr = i_cfg_valid & r_cfg_ready;

`ifdef CHANNEL_CFG_TIMEOUT_EN
  logic [31:0] r_wdog_cnt;

  // Watchdog counts ARMED cycles; held at zero elsewhere so it restarts on arming.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != ARMED)) r_wdog_cnt <= '0;
    else                             r_wdog_cnt <= r_wdog_cnt + 32'd1;
  end

  assign w_expire = (r_state == ARMED) && (r_wdog_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign w_expire         = 1'b0;
`endif

  // Next-state decode; a PPS edge outranks both abort and watchdog expiry.
  always_comb begin
    w_next    = r_state;
    w_apply   = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_commit) w_next = ARMED;
      end
      ARMED: begin
        if (w_rise) begin
          w_next  = DONE;
          w_apply = 1'b1;
        end else if (i_abort) begin
          w_next = IDLE;
        end else if (w_expire) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, registered status outputs, and shadow/active configuration banks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_cfg_ready   <= 1'b0;
      r_armed       <= 1'b0;
      r_commit_done <= 1'b0;
      r_timeout     <= 1'b0;
      r_shadow_en   <= '0;
      r_shadow_sel  <= '0;
      r_active_en   <= '0;
      r_active_sel  <= '0;
    end else begin
      r_state       <= w_next;
      r_cfg_ready   <= (w_next == IDLE);
      r_armed       <= (w_next == ARMED);
      r_commit_done <= w_apply;
      r_timeout     <= w_timeout;
      for (int unsigned i = 0; i < N_CHANNELS; i++) begin
        if (w_wr && (32'(i_cfg_channel) == i)) begin
          r_shadow_en[i]  <= i_cfg_enable;
          r_shadow_sel[i] <= i_cfg_selector;
        end
      end
      if (w_apply) begin
        r_active_en  <= r_shadow_en;
        r_active_sel <= r_shadow_sel;
      end
    end
  end

  assign o_cfg_ready   = r_cfg_ready;
  assign o_enable      = r_active_en;
  assign o_selector    = r_active_sel;
  assign o_armed       = r_armed;
  assign o_commit_done = r_commit_done;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_channel_cfg_scheduler.sv
// Directed bench for channel_cfg_scheduler. Uses N_CHANNELS=5 so the 3-bit
// channel index can express out-of-range targets (5..7).
module tb_channel_cfg_scheduler;

  localparam int unsigned N  = 5;
  localparam int unsigned TO = 10;
`ifdef CHANNEL_CFG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, pps, cfg_valid, cfg_ready, cfg_enable, cfg_selector;
  logic         commit, abort, armed, commit_done, timeout;
  logic [2:0]   cfg_channel;
  logic [N-1:0] enable, selector;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  channel_cfg_scheduler #(.N_CHANNELS(N), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pps         (pps),
    .i_cfg_valid   (cfg_valid),
    .o_cfg_ready   (cfg_ready),
    .i_cfg_channel (cfg_channel),
    .i_cfg_enable  (cfg_enable),
    .i_cfg_selector(cfg_selector),
    .i_commit      (commit),
    .i_abort       (abort),
    .o_enable      (enable),
    .o_selector    (selector),
    .o_armed       (armed),
    .o_commit_done (commit_done),
    .o_timeout     (timeout)
  );

  typedef struct {
    logic         rst, valid;
    logic [2:0]   ch;
    logic         en, sel, commit, abort, pps;
    logic [N-1:0] e_en, e_sel;
    logic         e_ready, e_armed, e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, v, input logic [2:0] c, input logic e, s, cm, ab, p,
                              input logic [N-1:0] ee, es, input logic er, ea, ed);
    vec_t t;
    t.rst = r; t.valid = v; t.ch = c; t.en = e; t.sel = s; t.commit = cm; t.abort = ab; t.pps = p;
    t.e_en = ee; t.e_sel = es; t.e_ready = er; t.e_armed = ea; t.e_done = ed;
    return t;
  endfunction

  task automatic drive(input logic r, v, input logic [2:0] c, input logic e, s, cm, ab, p);
    rst = r; cfg_valid = v; cfg_channel = c; cfg_enable = e; cfg_selector = s;
    commit = cm; abort = ab; pps = p;
  endtask

  // Advance one clock and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare {ready, armed, done, timeout, enable, selector} against expectation.
  task automatic chk(input string name, input logic [4+2*N-1:0] exp);
    logic [4+2*N-1:0] got;
    got = {cfg_ready, armed, commit_done, timeout, enable, selector};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy/arm/done/to=%b en=%b sel=%b, want rdy/arm/done/to=%b en=%b sel=%b",
               name, got[4+2*N-1 -: 4], got[2*N-1 -: N], got[N-1:0],
               exp[4+2*N-1 -: 4], exp[2*N-1 -: N], exp[N-1:0]);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    //                 rst v ch en sel cm ab pps  e_en      e_sel     rdy arm done
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0)); // 0 reset
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1, 0, 0)); // 1 idle
    tbl.push_back(mk(0, 1, 2, 1, 1, 0, 0, 0, 5'b00000, 5'b00000, 1, 0, 0)); // 2 write ch2
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b00000, 0, 1, 0)); // 3 commit
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 0)); // 4 wait
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00100, 5'b00100, 0, 0, 1)); // 5 pps edge
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00100, 5'b00100, 1, 0, 0)); // 6
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 5'b00100, 1, 0, 0)); // 7
    tbl.push_back(mk(0, 1, 1, 1, 0, 1, 0, 1, 5'b00100, 5'b00100, 0, 1, 0)); // 8 write+commit, edge on arm
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00100, 5'b00100, 0, 1, 0)); // 9
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 5'b00100, 0, 1, 0)); // 10
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00110, 5'b00100, 0, 0, 1)); // 11 commit ch1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 5'b00100, 1, 0, 0)); // 12
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00110, 5'b00100, 1, 0, 0)); // 13 pps in idle
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 5'b00100, 1, 0, 0)); // 14
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 5'b00110, 5'b00100, 1, 0, 0)); // 15 write ch0
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b00110, 5'b00100, 0, 1, 0)); // 16 commit
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 5'b00111, 5'b00101, 0, 0, 1)); // 17 abort+pps: pps wins
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b00101, 1, 0, 0)); // 18
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 5'b00111, 5'b00101, 1, 0, 0)); // 19 clear ch2 shadow
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b00111, 5'b00101, 0, 1, 0)); // 20 commit
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00111, 5'b00101, 1, 0, 0)); // 21 abort
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00111, 5'b00101, 1, 0, 0)); // 22 pps idle
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b00101, 1, 0, 0)); // 23
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b00111, 5'b00101, 0, 1, 0)); // 24 recommit
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00011, 5'b00001, 0, 0, 1)); // 25 retained shadow
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00011, 5'b00001, 1, 0, 0)); // 26
    tbl.push_back(mk(0, 1, 5, 1, 1, 0, 0, 0, 5'b00011, 5'b00001, 1, 0, 0)); // 27 ch5 out of range
    tbl.push_back(mk(0, 1, 7, 1, 1, 0, 0, 0, 5'b00011, 5'b00001, 1, 0, 0)); // 28 ch7 out of range
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b00011, 5'b00001, 0, 1, 0)); // 29 commit
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00011, 5'b00001, 0, 0, 1)); // 30 no change
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00011, 5'b00001, 1, 0, 0)); // 31
    tbl.push_back(mk(0, 1, 4, 1, 1, 0, 0, 0, 5'b00011, 5'b00001, 1, 0, 0)); // 32 write ch4
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b00011, 5'b00001, 0, 1, 0)); // 33 commit
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0)); // 34 reset mid-armed
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1, 0, 0)); // 35
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 1, 0, 0)); // 36 pps after reset
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1, 0, 0)); // 37
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b00000, 0, 1, 0)); // 38 commit
    tbl.push_back(mk(0, 1, 3, 1, 1, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 0)); // 39 stalled write
    tbl.push_back(mk(0, 1, 3, 1, 1, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 0)); // 40
    tbl.push_back(mk(0, 1, 3, 1, 1, 0, 0, 1, 5'b00000, 5'b00000, 0, 0, 1)); // 41 edge, old shadow
    tbl.push_back(mk(0, 1, 3, 1, 1, 0, 0, 0, 5'b00000, 5'b00000, 1, 0, 0)); // 42
    tbl.push_back(mk(0, 1, 3, 1, 1, 0, 0, 0, 5'b00000, 5'b00000, 1, 0, 0)); // 43 handshake
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b00000, 0, 1, 0)); // 44 commit
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b01000, 5'b01000, 0, 0, 1)); // 45 ch3 applied
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 5'b01000, 1, 0, 0)); // 46

    step();
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].ch, tbl[i].en, tbl[i].sel,
            tbl[i].commit, tbl[i].abort, tbl[i].pps);
      step();
      chk($sformatf("vec%0d", i),
          {tbl[i].e_ready, tbl[i].e_armed, tbl[i].e_done, 1'b0, tbl[i].e_en, tbl[i].e_sel});
    end

    // PPS edge on the same cycle the watchdog would expire: commit wins.
    drive(0, 1, 0, 1, 0, 0, 0, 0); step();
    chk("wr_ch0", {4'b1000, 5'b01000, 5'b01000});
    drive(0, 0, 0, 0, 0, 1, 0, 0); step();
    for (int k = 1; k <= int'(TO) - 1; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0); step();
      chk($sformatf("race_wait%0d", k), {4'b0100, 5'b01000, 5'b01000});
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("race_pps_wins", {4'b0010, 5'b01001, 5'b01000});
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("race_idle", {4'b1000, 5'b01001, 5'b01000});

    // Arm with no PPS: watchdog expiry when built in, otherwise waits forever.
    drive(0, 0, 0, 0, 0, 1, 0, 0); step();
    chk("to_armed", {4'b0100, 5'b01001, 5'b01000});
    for (int k = 1; k <= int'(TO) + 2; k++) begin
      logic e_rdy, e_arm, e_to;
      drive(0, 0, 0, 0, 0, 0, 0, 0); step();
      e_to  = TO_EN && (k == int'(TO));
      e_arm = TO_EN ? (k < int'(TO)) : 1'b1;
      e_rdy = ~e_arm;
      chk($sformatf("to_cyc%0d", k), {e_rdy, e_arm, 1'b0, e_to, 5'b01001, 5'b01000});
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    chk("to_abort_idle", {4'b1000, 5'b01001, 5'b01000});
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
